address_compose: RTL and testbench
==================================

// Module: address_compose
// PURPOSE
//  Inverse of the cache address split. Rebuilds memory byte addresses from a
//  {tag, index, byte_select} triple and streams them to the memory side.
//  Used for line fills and victim writebacks. Full-line requests are emitted as a
//  critical-word-first burst that wraps inside the line; single requests are one beat.
//  Sits between the cache controller (request side) and the memory port (address side).
// PARAMETERS
//  i_size      64  address width in bits
//  d_size      6   byte_select width; line = 2**d_size bytes
//  w_size      3   log2(bytes per memory beat); beats per line = 2**(d_size-w_size)
//  index_bits  -   from mypkg (5 for the 16 KiB, 8-way, 64 B-line config)
//  tag_bits    -   from mypkg; tag_bits + index_bits + d_size == i_size (elab check)
// PORTS
//  clk              in   1           clock, all logic on rising edge
//  rst              in   1           synchronous, active-high reset
//  req_valid        in   1           request present
//  req_ready        out  1           block can accept a request (IDLE only)
//  req_tag          in   tag_bits    tag of target line
//  req_index        in   index_bits  set index of target line
//  req_byte_select  in   d_size      byte offset (start point for bursts)
//  req_is_line      in   1           1 = full-line burst, 0 = single byte address
//  addr_valid       out  1           addr holds a valid beat address
//  addr_ready       in   1           memory side accepts current beat
//  addr             out  i_size      composed byte address
//  addr_last        out  1           current beat is the final one of the request
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=1; addr_valid=0; addr=0; addr_last=0; beat count=0.
//  States: IDLE, BURST.
//  IDLE: req_ready=1. On req_valid&&req_ready, capture all req_* fields and go BURST.
//   First beat is registered: addr_valid=1 on the cycle after acceptance (1-cycle latency).
//  Composition: addr = {tag, index, off}. off = req_byte_select for single requests.
//   For line requests, off = {word, w_size'b0}. word starts at
//   req_byte_select[d_size-1:w_size] and increments mod 2**(d_size-w_size). No carry into index.
//  BURST: addr_valid=1. addr and addr_last are stable while addr_valid && !addr_ready.
//   On addr_valid&&addr_ready, advance to the next beat, or finish if addr_last=1.
//   addr_last=1 on the single beat, or on the 2**(d_size-w_size)-th beat of a line.
//  Last beat accepted: next cycle state=IDLE, addr_valid=0, addr_last=0, req_ready=1.
//   addr holds its last value.
//   No new request is accepted in the same cycle the last beat is accepted.
//   Min spacing between requests is beats+1 cycles.
//  req_valid while busy: req_ready=0, so nothing is captured. Requester must hold its request.
//  req_* inputs changing during BURST have no effect (captured copy is used).
//  rst has priority over every event. Asserting rst mid-burst abandons remaining beats.
//   Outputs take reset values on the next edge.
//  Beat counter width = d_size-w_size bits. Wrap is natural overflow of this counter.
// TESTING
//  Single: tag=1, idx=3, bs=0x2A, line=0 -> one beat addr=0x8EA, last=1.
//   Then req_ready=1 the following cycle.
//  Aligned line: tag=1, idx=3, bs=0x00, addr_ready=1 -> 0x8C0,0x8C8,..,0x8F8 on 8 consecutive cycles.
//   last=1 only on 0x8F8.
//  Wrapped line: tag=1, idx=3, bs=0x2C -> 0x8E8,0x8F0,0x8F8,0x8C0,0x8C8,0x8D0,0x8D8,0x8E0.
//   last on 0x8E0; index never increments.
//  Backpressure: drop addr_ready for 3 cycles after beat 2 of aligned line.
//   addr stays 0x8D0 and addr_valid stays 1; all 8 beats still delivered once each, in order.
//  Reset mid-burst: rst=1 after beat 3 accepted -> next cycle addr_valid=0, addr=0, req_ready=1.
//   A new request then starts cleanly.
//  Extremes: tag=all 1s, idx=31, bs=63, line=0 -> addr=0xFFFF_FFFF_FFFF_FFFF.
//   req_valid during a burst -> req_ready=0 and the request is not captured.

Source files
------------

// File: rtl/address_compose.sv
// Rebuilds memory byte addresses from a {tag, index, byte_select} triple.
// Line requests go out as a critical-word-first burst that wraps inside the line.
module address_compose #(
  parameter int i_size     = 64,
  parameter int d_size     = 6,
  parameter int w_size     = 3,
  parameter int index_bits = 5,
  parameter int tag_bits   = i_size - index_bits - d_size
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [tag_bits-1:0]   req_tag,
  input  logic [index_bits-1:0] req_index,
  input  logic [d_size-1:0]     req_byte_select,
  input  logic                  req_is_line,
  output logic                  addr_valid,
  input  logic                  addr_ready,
  output logic [i_size-1:0]     addr,
  output logic                  addr_last
);

  localparam int cnt_bits = d_size - w_size;
  localparam logic [cnt_bits-1:0] penult_beat = cnt_bits'((1 << cnt_bits) - 2);

  if (tag_bits + index_bits + d_size != i_size) begin : g_width_check
    $error("address_compose: tag_bits + index_bits + d_size must equal i_size");
  end
  if (w_size >= d_size) begin : g_beat_check
    $error("address_compose: a line must hold at least two memory beats");
  end

  typedef enum logic {IDLE, BURST} state_t;

  state_t              state;
  state_t              state_next;
  logic [cnt_bits-1:0] beat_cnt;
  logic [d_size-1:0]   start_off;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    addr_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = BURST;
      end
      BURST: begin
        addr_valid = 1'b1;
        if (addr_ready && addr_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Line bursts start on the beat holding the requested byte.
  assign start_off = req_is_line ? {req_byte_select[d_size-1:w_size], {w_size{1'b0}}}
                                 : req_byte_select;

  // addr is the captured copy; only its word field moves during a burst, so
  // the wrap never carries into the index.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr      <= '0;
      addr_last <= 1'b0;
      beat_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr      <= {req_tag, req_index, start_off};
            addr_last <= !req_is_line;
            beat_cnt  <= '0;
          end
        end
        BURST: begin
          if (addr_ready) begin
            if (addr_last) begin
              addr_last <= 1'b0;
            end else begin
              addr[d_size-1:w_size] <= addr[d_size-1:w_size] + 1'b1;
              beat_cnt              <= beat_cnt + 1'b1;
              addr_last             <= (beat_cnt == penult_beat);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_address_compose.sv
// Bench for address_compose: directed literal cases plus randomized traffic
// checked every cycle against a queue-based model of the emitted beat list.
module tb_address_compose;

  localparam int IS = 64;
  localparam int DS = 6;
  localparam int WS = 3;
  localparam int IB = 5;
  localparam int TB = IS - IB - DS;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [TB-1:0] req_tag = '0;
  logic [IB-1:0] req_index = '0;
  logic [DS-1:0] req_byte_select = '0;
  logic          req_is_line = 1'b0;
  logic          addr_valid;
  logic          addr_ready = 1'b1;
  logic [IS-1:0] addr;
  logic          addr_last;

  int total = 0;
  int bad = 0;

  address_compose #(.i_size(IS), .d_size(DS), .w_size(WS), .index_bits(IB)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_tag(req_tag), .req_index(req_index),
    .req_byte_select(req_byte_select), .req_is_line(req_is_line),
    .addr_valid(addr_valid), .addr_ready(addr_ready),
    .addr(addr), .addr_last(addr_last)
  );

  always #5 clk = ~clk;

  logic [63:0] exp_aligned[8] = '{64'h8C0, 64'h8C8, 64'h8D0, 64'h8D8,
                                  64'h8E0, 64'h8E8, 64'h8F0, 64'h8F8};
  logic [63:0] exp_wrap[8]    = '{64'h8E8, 64'h8F0, 64'h8F8, 64'h8C0,
                                  64'h8C8, 64'h8D0, 64'h8D8, 64'h8E0};
  logic [63:0] exp_single[8]  = '{64'h8EA, 64'h0, 64'h0, 64'h0,
                                  64'h0, 64'h0, 64'h0, 64'h0};
  logic [63:0] exp_reset[8]   = '{64'h8C0, 64'h8C8, 64'h8D0, 64'h0,
                                  64'h0, 64'h0, 64'h0, 64'h0};

  // Model state: the beats still owed for the current request, plus the
  // address left on the bus once the request is finished.
  logic [63:0] mq[$];
  logic [63:0] bq[$];
  logic [63:0] dut_log[$];
  bit          m_busy = 1'b0;
  logic [63:0] m_held = '0;
  bit          check_en = 1'b0;

  function automatic void build(logic [TB-1:0] t, logic [IB-1:0] i,
                                logic [DS-1:0] b, logic line);
    logic [63:0] base;
    int w;
    bq.delete();
    base = {t, i, 6'd0};
    if (!line) begin
      bq.push_back(base + 64'(b));
    end else begin
      for (int k = 0; k < 8; k++) begin
        w = (int'(b) / 8 + k) % 8;
        bq.push_back(base + 64'(w * 8));
      end
    end
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_busy = 1'b0;
      m_held = '0;
      check_en = 1'b1;
    end else if (m_busy) begin
      if (addr_ready) begin
        m_held = mq.pop_front();
        if (mq.size() == 0) m_busy = 1'b0;
      end
    end else if (req_valid) begin
      build(req_tag, req_index, req_byte_select, req_is_line);
      foreach (bq[k]) mq.push_back(bq[k]);
      m_busy = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("req_ready", {63'd0, req_ready}, {63'd0, !m_busy});
      checkOutput("addr_valid", {63'd0, addr_valid}, {63'd0, m_busy});
      checkOutput("addr", addr, m_busy ? mq[0] : m_held);
      checkOutput("addr_last", {63'd0, addr_last},
                  {63'd0, m_busy && (mq.size() == 1)});
      if (!rst && addr_valid && addr_ready) dut_log.push_back(addr);
    end
  end

  task automatic applyStimulus(input logic [TB-1:0] t, input logic [IB-1:0] i,
                               input logic [DS-1:0] b, input logic line);
    @(posedge clk); #2;
    req_tag = t; req_index = i; req_byte_select = b; req_is_line = line;
    req_valid = 1'b1;
    @(posedge clk); #2;
    req_valid = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    bit done;
    done = 1'b0;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (!addr_valid) done = 1'b1;
    end
    if (!done) begin
      total++; bad++;
      $display("[TB] FAIL %s: burst did not finish within 100 cycles", name);
    end
  endtask

  task automatic checkLog(input string name, input logic [63:0] e[8], input int n);
    checkOutput({name, "_count"}, 64'(dut_log.size()), 64'(n));
    for (int k = 0; k < n && k < dut_log.size(); k++)
      checkOutput($sformatf("%s_beat%0d", name, k), dut_log[k], e[k]);
  endtask

  initial begin
    logic [63:0] r;
    // Pin the model against hand-computed beat lists.
    build(53'd1, 5'd3, 6'h2C, 1'b1);
    for (int k = 0; k < 8; k++) checkOutput($sformatf("model_wrap%0d", k), bq[k], exp_wrap[k]);
    build(53'd1, 5'd3, 6'h2A, 1'b0);
    checkOutput("model_single", bq[0], 64'h8EA);

    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_addr", addr, 64'h0);
    checkOutput("reset_ready", {63'd0, req_ready}, 64'd1);

    dut_log.delete();
    applyStimulus(53'd1, 5'd3, 6'h2A, 1'b0);
    waitIdle("single");
    checkOutput("single_ready_after", {63'd0, req_ready}, 64'd1);
    checkLog("single", exp_single, 1);

    dut_log.delete();
    applyStimulus(53'd1, 5'd3, 6'h00, 1'b1);
    waitIdle("aligned");
    checkLog("aligned", exp_aligned, 8);

    dut_log.delete();
    applyStimulus(53'd1, 5'd3, 6'h2C, 1'b1);
    waitIdle("wrap");
    checkLog("wrap", exp_wrap, 8);

    dut_log.delete();
    applyStimulus(53'd1, 5'd3, 6'h00, 1'b1);
    repeat (2) @(posedge clk);
    #2 addr_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("stall_addr", addr, 64'h8D0);
      checkOutput("stall_valid", {63'd0, addr_valid}, 64'd1);
    end
    @(posedge clk); #2 addr_ready = 1'b1;
    waitIdle("backpressure");
    checkLog("backpressure", exp_aligned, 8);

    dut_log.delete();
    applyStimulus(53'd1, 5'd3, 6'h00, 1'b1);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_valid", {63'd0, addr_valid}, 64'd0);
    checkOutput("midrst_addr", addr, 64'h0);
    checkOutput("midrst_ready", {63'd0, req_ready}, 64'd1);
    checkLog("midrst", exp_reset, 3);

    applyStimulus({TB{1'b1}}, 5'd31, 6'd63, 1'b0);
    @(negedge clk);
    checkOutput("extreme_addr", addr, 64'hFFFF_FFFF_FFFF_FFFF);
    waitIdle("extreme");

    // A request arriving mid-burst must be ignored.
    dut_log.delete();
    addr_ready = 1'b0;
    applyStimulus(53'd1, 5'd3, 6'h00, 1'b1);
    req_tag = 53'h5; req_index = 5'd9; req_byte_select = 6'h11; req_is_line = 1'b0;
    req_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("busy_ready", {63'd0, req_ready}, 64'd0);
    end
    @(posedge clk); #2 req_valid = 1'b0; addr_ready = 1'b1;
    waitIdle("busy");
    checkLog("busy", exp_aligned, 8);
    @(negedge clk);
    checkOutput("busy_no_capture", {63'd0, addr_valid}, 64'd0);

    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #2;
      rst = ($urandom_range(0, 299) == 0);
      addr_ready = ($urandom_range(0, 3) != 0);
      req_valid = ($urandom_range(0, 2) == 0);
      r = {$urandom(), $urandom()};
      req_tag = ($urandom_range(0, 9) == 0) ? {TB{1'b1}} : r[TB-1:0];
      req_index = IB'($urandom());
      req_byte_select = DS'($urandom());
      req_is_line = $urandom_range(0, 1) == 1;
    end
    @(posedge clk); #2;
    rst = 1'b0; req_valid = 1'b0; addr_ready = 1'b1;
    repeat (12) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
